// File: rtl/s_to_p.sv
// Serial-to-parallel converter: packs OWIDTH IWIDTH-bit words (first word in MSBs) into one output word.
// Optional S_TO_P_LAST_EN adds i_last/o_last for early emission of a zero-padded partial word.
module s_to_p #(
  parameter int IWIDTH = 8,
  parameter int OWIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IWIDTH-1:0]        i_data,
  input  logic                     i_valid,
  output logic                     i_ready,
`ifdef S_TO_P_LAST_EN
  input  logic                     i_last,
  output logic                     o_last,
`endif
  output logic [IWIDTH*OWIDTH-1:0] o_data,
  output logic                     o_valid,
  input  logic                     o_ready
);

  localparam int OW = IWIDTH * OWIDTH;
  localparam int CW = (OWIDTH > 1) ? $clog2(OWIDTH) : 1;

  logic [CW-1:0] cnt;
  logic [OW-1:0] acc;
  logic [OW-1:0] merged;
  logic          last_in;
  logic          emit;
  logic          in_xfer;

`ifdef S_TO_P_LAST_EN
  assign last_in = i_last;
`else
  assign last_in = 1'b0;
`endif

  // Slots above cnt are always zero, so merged is also the zero-padded partial word.
  always_comb begin
    merged = acc;
    for (int unsigned k = 0; k < OWIDTH; k++) begin
      if (k == 32'(cnt)) merged[OW-1-IWIDTH*k -: IWIDTH] = i_data;
    end
  end

  assign emit    = (cnt == CW'(OWIDTH - 1)) || last_in;
  assign i_ready = rst && (!emit || !o_valid || o_ready);
  assign in_xfer = i_valid && i_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= '0;
      acc     <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
`ifdef S_TO_P_LAST_EN
      o_last  <= 1'b0;
`endif
    end else begin
      if (o_valid && o_ready) o_valid <= 1'b0;
      if (in_xfer) begin
        if (emit) begin
          o_data  <= merged;
          o_valid <= 1'b1;
          cnt     <= '0;
          acc     <= '0;
`ifdef S_TO_P_LAST_EN
          o_last  <= i_last;
`endif
        end else begin
          acc <= merged;
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_s_to_p.sv
// Scoreboard bench for s_to_p (IWIDTH=8, OWIDTH=4); covers the S_TO_P_LAST_EN build when defined.
module tb_s_to_p;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  i_data = '0;
  logic        i_valid = 1'b0;
  logic        i_ready;
  logic        i_last = 1'b0;
  logic        o_last_w;
  logic [31:0] o_data;
  logic        o_valid;
  logic        o_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [32:0] exp_q[$];
  int          out_cyc[$];
  logic [31:0] exp_acc = '0;
  int          exp_cnt = 0;

  s_to_p #(.IWIDTH(8), .OWIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_data  (i_data),
    .i_valid (i_valid),
    .i_ready (i_ready),
`ifdef S_TO_P_LAST_EN
    .i_last  (i_last),
    .o_last  (o_last_w),
`endif
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_ready (o_ready)
  );

`ifndef S_TO_P_LAST_EN
  assign o_last_w = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference packing model, stepped once per accepted input word.
  task automatic model_accept(input logic [7:0] w, input logic l);
    exp_acc[31 - 8*exp_cnt -: 8] = w;
    if (exp_cnt == 3 || l) begin
      exp_q.push_back({l, exp_acc});
      exp_acc = '0;
      exp_cnt = 0;
    end else begin
      exp_cnt++;
    end
  endtask

  task automatic send(input logic [7:0] w, input logic l, output int waits);
    i_data  = w;
    i_last  = l;
    i_valid = 1'b1;
    waits   = 0;
    @(negedge clk);
    while (!i_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!i_ready) check("send_timeout", 0, 1);
    else model_accept(w, l);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    i_last  = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Output monitor: o_valid && o_ready at the negedge is the transfer at the next posedge.
  always @(negedge clk) begin
    if (rst && o_valid && o_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", {32'h0, o_data}, 64'hFFFF_FFFF);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("sb_data", {32'h0, o_data}, {32'h0, e[31:0]});
`ifdef S_TO_P_LAST_EN
        check("sb_last", {63'h0, o_last_w}, {63'h0, e[32]});
`endif
      end
      out_cyc.push_back(cyc);
    end
  end

  initial begin
    int w;
    logic [7:0] words[4];

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ovalid", {63'h0, o_valid}, 0);
    check("rst_odata", {32'h0, o_data}, 0);
    check("rst_iready", {63'h0, i_ready}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rel_iready", {63'h0, i_ready}, 1);
    @(posedge clk); #1;

    // Basic pack
    o_ready = 1'b1;
    words = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    foreach (words[k]) send(words[k], 1'b0, w);
    i_valid = 1'b0;
    @(negedge clk);
    check("basic_ovalid", {63'h0, o_valid}, 1);
    check("basic_odata", {32'h0, o_data}, 64'hDEADBEEF);
    idle(2);

    // Throughput
    out_cyc.delete();
    for (int i = 0; i < 16; i++) begin
      send(8'(i), 1'b0, w);
      check("tput_waits", w, 0);
    end
    idle(3);
    check("tput_count", out_cyc.size(), 4);
    for (int i = 1; i < out_cyc.size(); i++) check("tput_spacing", out_cyc[i] - out_cyc[i-1], 4);

    // Backpressure
    o_ready = 1'b0;
    foreach (words[k]) send(words[k], 1'b0, w);
    send(8'h11, 1'b0, w); check("bp_w11", w, 0);
    send(8'h22, 1'b0, w); check("bp_w22", w, 0);
    send(8'h33, 1'b0, w); check("bp_w33", w, 0);
    i_data = 8'h44; i_valid = 1'b1;
    @(negedge clk);
    check("bp_iready_low", {63'h0, i_ready}, 0);
    check("bp_hold_valid", {63'h0, o_valid}, 1);
    check("bp_hold_data", {32'h0, o_data}, 64'hDEADBEEF);
    @(posedge clk); #1;
    check("bp_hold_data2", {32'h0, o_data}, 64'hDEADBEEF);
    o_ready = 1'b1;
    @(negedge clk);
    check("bp_iready_high", {63'h0, i_ready}, 1);
    model_accept(8'h44, 1'b0);
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(negedge clk);
    check("bp_next", {32'h0, o_data}, 64'h11223344);
    check("bp_next_valid", {63'h0, o_valid}, 1);
    idle(2);

    // Gaps between words
    words = '{8'hC0, 8'hFF, 8'hEE, 8'h01};
    foreach (words[k]) begin
      send(words[k], 1'b0, w);
      if (k < 3) begin
        idle(2);
        check("gap_novalid", {63'h0, o_valid}, 0);
      end
    end
    idle(3);

    // Reset mid-word
    send(8'hAA, 1'b0, w);
    send(8'hBB, 1'b0, w);
    i_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_iready", {63'h0, i_ready}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_acc = '0;
    exp_cnt = 0;
    check("midrst_ovalid", {63'h0, o_valid}, 0);
    words = '{8'h01, 8'h02, 8'h03, 8'h04};
    foreach (words[k]) send(words[k], 1'b0, w);
    i_valid = 1'b0;
    @(negedge clk);
    check("midrst_odata", {32'h0, o_data}, 64'h01020304);
    idle(2);

`ifdef S_TO_P_LAST_EN
    send(8'hAA, 1'b0, w);
    send(8'hBB, 1'b1, w);
    i_valid = 1'b0; i_last = 1'b0;
    @(negedge clk);
    check("last_odata", {32'h0, o_data}, 64'hAABB0000);
    check("last_olast", {63'h0, o_last_w}, 1);
    idle(1);
    foreach (words[k]) send(words[k], 1'b0, w);
    i_valid = 1'b0;
    @(negedge clk);
    check("full_olast", {63'h0, o_last_w}, 0);
    idle(2);
`endif

    // Drain
    o_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/s_to_p.md
Name: s_to_p

Overview:
Serial-to-parallel width converter with valid/ready handshaking. It gathers OWIDTH consecutive IWIDTH-bit input words into one IWIDTH*OWIDTH-bit output word. It sits between a narrow symbol or byte stream and a wide consumer, for example packing bytes into 32-bit words for the OFDM datapath. Full throughput: one input word per cycle when downstream is ready.

Parameters:
IWIDTH, 8, width of each input word in bits (>=1)
OWIDTH, 4, number of input words packed per output word (>=1)

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous, active-low reset
i_data  input  IWIDTH  input word
i_valid  input  1  i_data valid
i_ready  output  1  converter can accept i_data this cycle
o_data  output  IWIDTH*OWIDTH  packed output word
o_valid  output  1  o_data valid
o_ready  input  1  downstream accepts o_data this cycle

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst==0 at rising clk edge):
  - o_valid=0, o_data=0, word counter=0, accumulator=0.
  - i_ready is forced 0 combinationally while rst==0.
- Input transfer = i_valid && i_ready at a rising edge. Output transfer = o_valid && o_ready at a rising edge.
- Word counter cnt runs 0..OWIDTH-1 and counts words held in the accumulator.
- Packing order: the first accepted word lands in o_data[IWIDTH*OWIDTH-1 -: IWIDTH] (MSBs); the last lands in o_data[IWIDTH-1:0].
- Non-final input (cnt<OWIDTH-1): word stored in accumulator slot cnt; cnt increments.
- Final input (cnt==OWIDTH-1):
  - Accumulator plus this word are loaded into the o_data register; o_valid<=1; cnt<=0; accumulator cleared.
  - Latency: o_valid is high in the cycle after the edge that accepted the final word.
- i_ready = rst && ((cnt!=OWIDTH-1) || !o_valid || o_ready).
  - Non-final words are always accepted, even while o_valid is stalled.
  - The final word is accepted only if the output register is empty or is being drained in the same cycle.
- Output register:
  - o_valid clears after an output transfer unless a new word is loaded at the same edge, in which case it stays 1 with new data. This is the simultaneous case.
  - o_data and o_valid hold stable while o_valid && !o_ready.
- i_data is ignored when i_valid==0. o_ready is ignored when o_valid==0.
- OWIDTH==1: every accepted word goes straight to the output register, giving a one-deep pipeline register.
- Reset mid-word: a partially filled accumulator is discarded and o_valid drops. No partial word is ever emitted except through the optional feature below.
- No overflow or underflow is possible; backpressure propagates through i_ready.

Optional Feature:
- Macro S_TO_P_LAST_EN adds two ports: input i_last (1) and output o_last (1).
- With the macro:
  - If an input transfer has i_last==1, the packed word is emitted immediately even when cnt<OWIDTH-1.
  - Unfilled lower slots are zero.
  - o_last=1 accompanies that output word.
  - i_ready additionally requires (!o_valid || o_ready) whenever i_last==1.
  - o_last resets to 0 and holds with o_data.
- Without the macro: no i_last or o_last ports, and only full words are emitted.

Test Plan:
1. Reset: hold rst=0 for 2 cycles -> o_valid=0, o_data=0, i_ready=0. Release rst -> i_ready=1 next cycle.
2. Basic pack: send DE, AD, BE, EF on consecutive cycles with o_ready=1 -> one cycle after EF, o_valid=1 and o_data=32'hDEADBEEF.
3. Throughput: stream 8'h00..8'h0F back-to-back with o_ready=1 -> i_ready stays 1 and outputs are 00010203, 04050607, 08090A0B, 0C0D0E0F on four cycles spaced 4 apart.
4. Backpressure: o_ready=0 after the first word DEADBEEF, then send 11, 22, 33 -> all accepted, and i_ready=0 while 44 is presented. Raising o_ready -> DEADBEEF transfers and 44 is accepted that same edge. Next cycle o_data=32'h11223344.
5. Gaps and reset mid-word: insert i_valid=0 bubbles between words -> output unchanged. Send AA, BB, then pulse rst=0, then send 01, 02, 03, 04 -> output 32'h01020304 with no trace of AA or BB.
6. (S_TO_P_LAST_EN) Send AA, then BB with i_last=1 -> o_data=32'hAABB0000 and o_last=1. The following full word has o_last=0.
